// File: rtl/frame2axis.sv
// frame2axis: Frame val/rdy stream to AXI4-Stream video with geometry repair.
// Define FRAME2AXIS_ERR_CNT_EN to add sts_frm_cnt / sts_err_cnt counters.
module frame2axis #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst,
  input  logic [15:0]           cfg_img_w,
  input  logic [15:0]           cfg_img_h,
  input  logic                  s_frm_val,
  output logic                  s_frm_rdy,
  input  logic [DATA_WIDTH-1:0] s_frm_data,
  input  logic                  s_frm_sof,
  input  logic                  s_frm_eof,
  input  logic                  s_frm_sol,
  input  logic                  s_frm_eol,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  sts_frm_done,
  output logic [3:0]            sts_err
`ifdef FRAME2AXIS_ERR_CNT_EN
  ,
  output logic [15:0]           sts_frm_cnt,
  output logic [15:0]           sts_err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  user;
    logic                  last;
    logic                  done;
  } beat_t;

  state_t      st_q, st_d;
  logic [11:0] w_q, w_d, h_q, h_d;
  logic [11:0] pix_q, pix_d, line_q, line_d;
  logic [11:0] ew, eh, ep, el;
  logic        last_pix, last_line, frame_end;
  logic        line_end, early_eof, go_drop;
  logic [3:0]  err_set, err_q;
  logic        fwd, acc, pop, rdy_q, done_q;
  logic [1:0]  cnt_q, cnt_d;
  beat_t       nb, e0_q, e1_q;
  logic        unused_in;

  assign unused_in = ^{cfg_img_w[15:12], cfg_img_h[15:12], s_frm_sol};

  assign acc = s_frm_val & rdy_q;
  assign pop = m_axis_tvalid & m_axis_tready;

  // Position of the incoming beat; a sof beat restarts at pixel 0, line 0
  always_comb begin
    ew = w_q;
    eh = h_q;
    ep = pix_q;
    el = line_q;
    if (s_frm_sof) begin
      ew = cfg_img_w[11:0];
      eh = cfg_img_h[11:0];
      ep = '0;
      el = '0;
    end
  end

  assign last_pix  = (ep == ew - 12'd1);
  assign last_line = (el == eh - 12'd1);
  assign frame_end = last_pix & last_line;
  assign line_end  = last_pix | s_frm_eol;
  assign early_eof = s_frm_eof & ~frame_end;
  assign go_drop   = last_pix & ~s_frm_eol & ~frame_end & ~s_frm_eof;

  // Next state, counters, error events and the beat to forward
  always_comb begin
    st_d    = st_q;
    w_d     = w_q;
    h_d     = h_q;
    pix_d   = pix_q;
    line_d  = line_q;
    err_set = '0;
    fwd     = 1'b0;
    nb      = '0;
    nb.data = s_frm_data;
    nb.user = s_frm_sof;
    nb.last = line_end | s_frm_eof;
    nb.done = frame_end;
    if (acc) begin
      if (s_frm_sof) begin
        w_d        = ew;
        h_d        = eh;
        err_set[2] = (st_q != IDLE);
      end
      if (s_frm_sof && (ew == '0 || eh == '0)) begin
        st_d = IDLE;
      end else if (s_frm_sof || st_q == ACTIVE) begin
        fwd        = 1'b1;
        err_set[0] = s_frm_eol & ~last_pix;
        err_set[1] = last_pix & ~s_frm_eol;
        err_set[3] = frame_end ^ s_frm_eof;
        unique case (1'b1)
          (frame_end | early_eof): st_d = IDLE;
          go_drop:                 st_d = DROP;
          default:                 st_d = ACTIVE;
        endcase
        if (go_drop) begin
          pix_d  = '0;
          line_d = el;
        end else if (line_end) begin
          pix_d  = '0;
          line_d = last_line ? '0 : el + 12'd1;
        end else begin
          pix_d  = ep + 12'd1;
          line_d = el;
        end
      end else if (st_q == DROP && s_frm_eol) begin
        pix_d  = '0;
        line_d = last_line ? '0 : line_q + 12'd1;
        st_d   = last_line ? IDLE : ACTIVE;
      end
    end
  end

  // Frame tracking state, latched geometry and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      w_q    <= '0;
      h_q    <= '0;
      pix_q  <= '0;
      line_q <= '0;
      err_q  <= '0;
    end else if (sw_rst) begin
      st_q   <= IDLE;
      w_q    <= '0;
      h_q    <= '0;
      pix_q  <= '0;
      line_q <= '0;
      err_q  <= '0;
    end else begin
      st_q   <= st_d;
      w_q    <= w_d;
      h_q    <= h_d;
      pix_q  <= pix_d;
      line_q <= line_d;
      err_q  <= err_q | err_set;
    end
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    cnt_d = cnt_q + {1'b0, fwd} - {1'b0, pop};
  end

  // Two-entry output buffer; entry 0 drives the AXIS port directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      e0_q   <= '0;
      e1_q   <= '0;
    end else if (sw_rst) begin
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
      e0_q   <= '0;
      e1_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rdy_q  <= (cnt_d != 2'd2);
      done_q <= pop & e0_q.done;
      case (cnt_q)
        2'd0: if (fwd) e0_q <= nb;
        2'd1: begin
          if (fwd && pop) e0_q <= nb;
          else if (fwd)   e1_q <= nb;
        end
        default: if (pop) e0_q <= e1_q;
      endcase
    end
  end

  assign s_frm_rdy     = rdy_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = e0_q.data;
  assign m_axis_tuser  = e0_q.user;
  assign m_axis_tlast  = e0_q.last;
  assign sts_frm_done  = done_q;
  assign sts_err       = err_q;

`ifdef FRAME2AXIS_ERR_CNT_EN
  logic [15:0] frm_cnt_q, err_cnt_q;

  // Saturating counts of completed frames and of beats raising an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (sw_rst) begin
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pop && e0_q.done && frm_cnt_q != 16'hFFFF)
        frm_cnt_q <= frm_cnt_q + 16'd1;
      if ((|err_set) && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign sts_frm_cnt = frm_cnt_q;
  assign sts_err_cnt = err_cnt_q;
`endif

endmodule
